random_range_gen: RTL and testbench
===================================

RANDOM_RANGE_GEN -- requirements
Module: random_range_gen

Interface
REQ-001 The block SHALL have parameter LFSR_W, default 16, meaning LFSR width (4..32).
REQ-002 The block SHALL have parameter TAPS, default 16'hB400, meaning feedback tap mask (bit i set = lfsr[i] in XOR).
REQ-003 The block SHALL have parameter SEED, default 16'hACE1, meaning the nonzero reset/substitute seed.
REQ-004 The block SHALL have parameter OUT_W, default 5, meaning result width.
REQ-005 The block SHALL have parameter MAX_RETRY, default 7, meaning rejections allowed before fold fallback.
REQ-006 The block SHALL have port clk, input, 1 bit: system clock, single clock domain.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 The block SHALL have port en, input, 1 bit: free-run advance enable for the LFSR.
REQ-009 The block SHALL have port seed_load, input, 1 bit: load seed_in into the LFSR.
REQ-010 The block SHALL have port seed_in, input, LFSR_W bits: seed value.
REQ-011 The block SHALL have port range_n, input, OUT_W bits: number of legal values (result in 0..range_n-1); 0 means 2^OUT_W.
REQ-012 The block SHALL have port req, input, 1 bit: draw request, sampled only in IDLE.
REQ-013 The block SHALL have port out_valid, output, 1 bit: result available.
REQ-014 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-015 The block SHALL have port out_pos, output, OUT_W bits: random result.
REQ-016 The block SHALL have port out_folded, output, 1 bit: the current result came from the fold fallback.
REQ-017 The block SHALL have port lfsr_state, output, LFSR_W bits: current LFSR contents, for debug.

Function
REQ-018 The LFSR SHALL be Fibonacci, shifting left: next = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}.
REQ-019 The LFSR SHALL advance on a clock edge when en=1 or state=DRAW; otherwise it SHALL hold.
REQ-020 seed_load=1 SHALL override advance: the LFSR loads seed_in, or SEED if seed_in==0; the all-zero state SHALL never be reachable.
REQ-021 The FSM SHALL have three states: IDLE, DRAW, HOLD.
REQ-022 In IDLE with req=1, the block SHALL capture range_n into range_q, clear the retry counter, and go to DRAW next cycle.
REQ-023 In DRAW, the block SHALL compute mask = smallest 2^k-1 >= range_q-1 (all ones when range_q==0; 0 when range_q==1) and raw = lfsr[OUT_W-1:0] & mask.
REQ-024 In DRAW, if raw < range_q (always true for range_q==0), the block SHALL register out_pos=raw and out_folded=0, then go to HOLD.
REQ-025 In DRAW, if raw >= range_q and retry < MAX_RETRY, the block SHALL increment retry and stay in DRAW, evaluating the advanced LFSR next cycle.
REQ-026 In DRAW, if raw >= range_q and retry == MAX_RETRY, the block SHALL register out_pos = raw - range_q and out_folded=1, then go to HOLD; the result is always < range_q because raw < 2*range_q.
REQ-027 out_valid SHALL be 1 exactly in HOLD; out_pos and out_folded SHALL stay stable until out_valid & out_ready.
REQ-028 On handshake in HOLD, the next state SHALL be DRAW if req=1 (range_n recaptured, retry cleared), else IDLE.
REQ-029 Minimum latency SHALL be 2 cycles from req sampled to out_valid=1; worst case SHALL be MAX_RETRY+2 cycles.
REQ-030 seed_load during DRAW SHALL NOT abort the draw; the next evaluation uses the loaded value and retry is unchanged.
REQ-031 Changes on range_n after capture SHALL NOT affect the draw in progress.
REQ-032 out_ready in IDLE or DRAW SHALL be ignored.

Reset
REQ-033 While rst_n=0, the block SHALL asynchronously set lfsr=SEED, state=IDLE, retry=0, out_valid=0, out_pos=0, out_folded=0.
REQ-034 Reset mid-draw or during HOLD SHALL discard the pending result with no output pulse.
REQ-035 Release of reset SHALL be synchronised externally; the first advance occurs on the first clock edge with rst_n=1.

Verification
REQ-036 Scenario: reset, en=1, no req -> lfsr_state sequence 0xACE1, 0x59C3, 0xB387, 0x670F, 0xCE1E.
REQ-037 Scenario: reset, en=0, range_n=18, req pulse -> DRAW evaluates 0xACE1, raw=1, out_valid high 2 cycles after req with out_pos=1, out_folded=0.
REQ-038 Scenario: en=0, seed_load seed_in=0x59C3, range_n=3, req -> rejects 0x59C3, 0xB387, 0x670F, accepts 0xCE1E: out_pos=2, out_folded=0, 5 cycles after req.
REQ-039 Scenario: as REQ-038 with MAX_RETRY=2 -> third evaluation (0x670F, raw=3) folds: out_pos=0, out_folded=1.
REQ-040 Scenario: seed_load with seed_in=0 -> lfsr_state=0xACE1 next cycle; hold out_ready=0 for 10 cycles in HOLD -> out_pos stable; random 100k draws with range_n=1..31 -> every out_pos < range_n (out_pos in 0..31 when range_n=0).

Source files
------------

// File: rtl/random_range_gen.sv
// Uniform random value in 0..range_n-1 from an LFSR, by masked rejection
// sampling with a bounded retry count and a fold fallback. Ports: clk,
// rst_n, en, seed_load, seed_in, range_n, req, out_ready (in); out_valid,
// out_pos, out_folded, lfsr_state (out).
module random_range_gen #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                OUT_W     = 5,
  parameter int                MAX_RETRY = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic [OUT_W-1:0]  range_n,
  input  logic              req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_pos,
  output logic              out_folded,
  output logic [LFSR_W-1:0] lfsr_state
);

  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0]  range_q, range_d;
  logic [OUT_W-1:0]  pos_q, pos_d;
  logic              fold_q, fold_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [OUT_W-1:0]  mask;
  logic [OUT_W-1:0]  raw;
  logic              fits;
  logic              start;

  // Smear range_q-1 rightwards: smallest 2^k-1 covering it.
  // range_q==0 wraps to all ones, range_q==1 gives zero.
  always_comb begin
    mask = range_q - OUT_W'(1);
    for (int i = 1; i < OUT_W; i = i * 2) begin
      mask = mask | (mask >> i);
    end
  end

  assign raw  = lfsr_q[OUT_W-1:0] & mask;
  assign fits = (range_q == '0) || (raw < range_q);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    range_d = range_q;
    pos_d   = pos_q;
    fold_d  = fold_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: start = req;
      DRAW: begin
        if (fits) begin
          pos_d   = raw;
          fold_d  = 1'b0;
          state_d = HOLD;
        end else if (retry_q == RETRY_LIM) begin
          // raw < 2*range_q, so one subtraction lands in range
          pos_d   = raw - range_q;
          fold_d  = 1'b1;
          state_d = HOLD;
        end else begin
          retry_d = retry_q + RW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          start   = req;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      state_d = DRAW;
      retry_d = '0;
      range_d = range_n;
    end
  end

  // Zero seed would lock the LFSR, so substitute SEED
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    end else if (en || state_q == DRAW) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= SEED;
      range_q <= '0;
      retry_q <= '0;
      pos_q   <= '0;
      fold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      range_q <= range_d;
      retry_q <= retry_d;
      pos_q   <= pos_d;
      fold_q  <= fold_d;
    end
  end

  assign out_valid  = (state_q == HOLD);
  assign out_pos    = pos_q;
  assign out_folded = fold_q;
  assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_random_range_gen.sv
// Bench for random_range_gen: directed scenarios with literal values
// plus randomized traffic checked against a draw-level model.
module tb_random_range_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic [4:0]  range_n = '0;
  logic        req = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_folded;
  logic [4:0]  out_pos;
  logic [15:0] lfsr_state;
  logic        out_valid2, out_folded2;
  logic [4:0]  out_pos2;
  logic [15:0] lfsr_state2;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  random_range_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .seed_load(seed_load), .seed_in(seed_in),
    .range_n(range_n), .req(req),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pos(out_pos), .out_folded(out_folded),
    .lfsr_state(lfsr_state)
  );

  random_range_gen #(.MAX_RETRY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .seed_load(seed_load), .seed_in(seed_in),
    .range_n(range_n), .req(req),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_pos(out_pos2), .out_folded(out_folded2),
    .lfsr_state(lfsr_state2)
  );

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Parity of tapped bits shifted in at the bottom
  function automatic logic [15:0] nxt(logic [15:0] x);
    int p;
    p = $countones(x & 16'hB400) % 2;
    return {x[14:0], p[0]};
  endfunction

  // Smallest all-ones value not below n-1
  function automatic int mask_of(int n);
    int m;
    m = 0;
    while (m < n - 1) m = m * 2 + 1;
    return m;
  endfunction

  // Draw-level model: one evaluation per busy cycle
  logic [15:0] m_lfsr;
  bit          m_busy, m_hold, m_fold;
  int          m_retry, m_range, m_pos;

  always @(posedge clk or negedge rst_n) begin : mdl
    logic [15:0] l;
    bit b, h, f, st, was_busy;
    int r, n, p, raw;
    if (!rst_n) begin
      m_lfsr  <= 16'hACE1;
      m_busy  <= 0;
      m_hold  <= 0;
      m_fold  <= 0;
      m_retry <= 0;
      m_range <= 32;
      m_pos   <= 0;
    end else begin
      l = m_lfsr; b = m_busy; h = m_hold; f = m_fold;
      r = m_retry; n = m_range; p = m_pos;
      st = 0; was_busy = b;
      if (h) begin
        if (out_ready) begin
          h = 0;
          st = req;
        end
      end else if (b) begin
        raw = int'(l[4:0]) & mask_of(n);
        if (raw < n) begin
          p = raw; f = 0; b = 0; h = 1;
        end else if (r < 7) begin
          r++;
        end else begin
          p = raw - n; f = 1; b = 0; h = 1;
        end
      end else begin
        st = req;
      end
      if (seed_load) l = (seed_in != 0) ? seed_in : 16'hACE1;
      else if (en || was_busy) l = nxt(l);
      if (st) begin
        b = 1; r = 0;
        n = (range_n == 0) ? 32 : int'(range_n);
      end
      m_lfsr <= l; m_busy <= b; m_hold <= h; m_fold <= f;
      m_retry <= r; m_range <= n; m_pos <= p;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("valid", 32'(out_valid), 32'(m_hold));
      check("lfsr", 32'(lfsr_state), 32'(m_lfsr));
      if (m_hold) begin
        check("pos", 32'(out_pos), 32'(m_pos));
        check("folded", 32'(out_folded), 32'(m_fold));
        check("in_range", 32'(int'(out_pos) < m_range), 32'd1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 0; en = 0; seed_load = 0; out_ready = 0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int lat, lat2, draws;
    logic [15:0] exp_seq [4];
    exp_seq[0] = 16'h59C3; exp_seq[1] = 16'hB387;
    exp_seq[2] = 16'h670F; exp_seq[3] = 16'hCE1E;

    do_reset();
    chk_on = 1;
    check("rst_lfsr", 32'(lfsr_state), 32'hACE1);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_pos", 32'(out_pos), 0);
    check("rst_folded", 32'(out_folded), 0);

    // free-running sequence
    en = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("seq", 32'(lfsr_state), 32'(exp_seq[i]));
    end
    en = 0;

    // single-shot accept
    do_reset();
    range_n = 18; req = 1;
    cyc();
    req = 0;
    check("lat2_early", 32'(out_valid), 0);
    cyc();
    check("lat2_valid", 32'(out_valid), 1);
    check("lat2_pos", 32'(out_pos), 1);
    check("lat2_fold", 32'(out_folded), 0);
    out_ready = 1;
    cyc();
    out_ready = 0;

    // retries, and fold in the MAX_RETRY=2 instance
    do_reset();
    seed_load = 1; seed_in = 16'h59C3;
    cyc();
    seed_load = 0;
    check("seed_load", 32'(lfsr_state), 32'h59C3);
    range_n = 3; req = 1;
    lat = 0; lat2 = 0;
    do begin
      cyc();
      req = 0;
      range_n = 31;
      lat++;
      if (out_valid2 && lat2 == 0) lat2 = lat;
    end while (!out_valid && lat < 20);
    check("retry_lat", 32'(lat), 5);
    check("retry_pos", 32'(out_pos), 2);
    check("retry_fold", 32'(out_folded), 0);
    check("fold_lat", 32'(lat2), 4);
    check("fold_pos", 32'(out_pos2), 0);
    check("fold_flag", 32'(out_folded2), 1);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("hold_pos", 32'(out_pos), 2);
      check("hold_valid", 32'(out_valid), 1);
    end
    out_ready = 1;
    cyc();
    out_ready = 0;

    // zero seed substitutes the default
    seed_load = 1; seed_in = 16'h0;
    cyc();
    seed_load = 0;
    check("seed_zero", 32'(lfsr_state), 32'hACE1);

    // reset while holding drops the result
    range_n = 0; req = 1;
    cyc();
    req = 0;
    cyc();
    check("pre_rst_valid", 32'(out_valid), 1);
    rst_n = 0;
    #1;
    check("async_valid", 32'(out_valid), 0);
    check("async_lfsr", 32'(lfsr_state), 32'hACE1);
    cyc();
    rst_n = 1;
    cyc();
    check("post_rst_valid", 32'(out_valid), 0);

    // randomized traffic
    draws = 0;
    for (int c = 0; c < 4000; c++) begin
      en = 1'($urandom_range(0, 1));
      seed_load = ($urandom_range(0, 15) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      range_n = 5'($urandom);
      req = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) draws++;
      if (c % 997 == 500) rst_n = 0;
      cyc();
      rst_n = 1;
    end
    req = 0; out_ready = 1;
    cyc();
    cyc();
    check("draws_seen", 32'(draws > 100), 1);
    chk_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
